// File: rtl/haze_pkg.sv
// -----------------------------------------------------------------------------
// haze_pkg
// Shared encodings for the haze-removal datapath.
//   CH_A/CH_B/CH_C/CH_NONE : 2-bit channel select codes, the same codes the
//                            datapath 3-input muxes use.
//   phase_e                : collection phase of the channel demultiplexer. Its
//                            encoding equals the tag expected in that phase.
// -----------------------------------------------------------------------------
package haze_pkg;

    localparam logic [1:0] CH_A    = 2'b00;
    localparam logic [1:0] CH_B    = 2'b01;
    localparam logic [1:0] CH_C    = 2'b10;
    localparam logic [1:0] CH_NONE = 2'b11;

    // Phase values reuse the channel codes, so the expected tag is the phase itself.
    typedef enum logic [1:0] {
        PH_A = 2'b00,
        PH_B = 2'b01,
        PH_C = 2'b10
    } phase_e;

endpackage : haze_pkg

// File: rtl/channel_demux_3.sv
// -----------------------------------------------------------------------------
// channel_demux_3
// Collects a time-multiplexed a/b/c channel stream (one tagged word per beat)
// and presents each completed triplet as three parallel words.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush               : synchronous drop of any partially collected triplet
//   in_data/in_sel      : channel word and its 2-bit tag (00 a, 01 b, 10 c)
//   in_valid/in_ready   : input beat handshake
//   out_a/out_b/out_c   : reassembled triplet
//   out_valid/out_ready : output triplet handshake
//   err                 : one-cycle pulse after an out-of-order or illegal tag
// -----------------------------------------------------------------------------
module channel_demux_3
    import haze_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    phase_e           phase_q, phase_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic             stall;
    logic             accept;
    logic             tag_ok;

    // Only the completing beat has to wait for a full output stage; earlier
    // beats of the next triplet keep collecting behind it.
    assign stall    = (phase_q == PH_C) && out_valid_q && !out_ready;
    assign in_ready = !flush && !stall;
    assign accept   = in_valid && in_ready;
    assign tag_ok   = (in_sel == logic'(1'b0) ? 1'b0 : 1'b0) | (in_sel == 2'(phase_q));

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves one unassigned, which would infer a latch.
    always_comb begin
        phase_d     = phase_q;
        a_d         = a_q;
        b_d         = b_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            phase_d = PH_A;
        end else if (accept) begin
            if (tag_ok) begin
                case (phase_q)
                    PH_A: begin
                        a_d     = in_data;
                        phase_d = PH_B;
                    end
                    PH_B: begin
                        b_d     = in_data;
                        phase_d = PH_C;
                    end
                    PH_C: begin
                        // Completion overrides the handshake clear above, so a
                        // draining triplet is replaced without a bubble.
                        out_a_d     = a_q;
                        out_b_d     = b_q;
                        out_c_d     = in_data;
                        out_valid_d = 1'b1;
                        phase_d     = PH_A;
                    end
                    default: phase_d = PH_A;
                endcase
            end else begin
                err_d = 1'b1;
                // A stray a-tag is taken as the start of a fresh triplet.
                if (in_sel == CH_A) begin
                    a_d     = in_data;
                    phase_d = PH_B;
                end else begin
                    phase_d = PH_A;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the collection registers are reset as well so a triplet
            // built from stale words can never appear after reset.
            phase_q     <= PH_A;
            a_q         <= '0;
            b_q         <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule : channel_demux_3

// File: tb/tb_channel_demux_3.sv
module tb_channel_demux_3;

    logic       clk;
    logic       rst_n;

    // 8-bit instance
    logic       flush;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_a, out_b, out_c;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    // 9-bit instance
    logic       flush9;
    logic [8:0] in_data9;
    logic [1:0] in_sel9;
    logic       in_valid9;
    logic       in_ready9;
    logic [8:0] out_a9, out_b9, out_c9;
    logic       out_valid9;
    logic       out_ready9;
    logic       err9;

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;
    int err9_cnt = 0;

    channel_demux_3 #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    channel_demux_3 #(.WIDTH(9)) u_dut9 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush9),
        .in_data   (in_data9),
        .in_sel    (in_sel9),
        .in_valid  (in_valid9),
        .in_ready  (in_ready9),
        .out_a     (out_a9),
        .out_b     (out_b9),
        .out_c     (out_c9),
        .out_valid (out_valid9),
        .out_ready (out_ready9),
        .err       (err9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // err is a registered pulse; count it mid-cycle.
    always @(negedge clk) begin
        if (err === 1'b1)  err_cnt++;
        if (err9 === 1'b1) err9_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] data);
        in_sel   = sel;
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_a"}, 32'(out_a), 32'(a));
        check({tag, "_b"}, 32'(out_b), 32'(b));
        check({tag, "_c"}, 32'(out_c), 32'(c));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_sel    = 2'b00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush9    = 1'b0;
        in_data9  = '0;
        in_sel9   = 2'b00;
        in_valid9 = 1'b0;
        out_ready9 = 1'b1;

        #22 rst_n = 1'b1;
        #1;
        // ---- reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_a", 32'(out_a), 32'd0);
        check("rst_c", 32'(out_c), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // ---- in-order stream
        send(2'b00, 8'h11);
        send(2'b01, 8'h22);
        send(2'b10, 8'h33);
        check_out("inorder", 8'h11, 8'h22, 8'h33);
        idle(1);
        check("inorder_valid_1cyc", 32'(out_valid), 32'd0);
        check("inorder_no_err", 32'(err_cnt), 32'd0);

        // ---- back-pressure
        out_ready = 1'b0;
        send(2'b00, 8'h01);
        send(2'b01, 8'h02);
        send(2'b10, 8'h03);
        check_out("bp_first", 8'h01, 8'h02, 8'h03);
        check("bp_ready_a", 32'(in_ready), 32'd1);
        send(2'b00, 8'h04);
        check("bp_ready_b", 32'(in_ready), 32'd1);
        send(2'b01, 8'h05);
        in_sel   = 2'b10;
        in_data  = 8'h06;
        in_valid = 1'b1;
        #1;
        check("bp_ready_c_stall", 32'(in_ready), 32'd0);
        idle(1);
        check("bp_ready_still_low", 32'(in_ready), 32'd0);
        check_out("bp_hold", 8'h01, 8'h02, 8'h03);
        out_ready = 1'b1;
        #1;
        check("bp_ready_released", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("bp_second", 8'h04, 8'h05, 8'h06);
        idle(1);
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_no_err", 32'(err_cnt), 32'd0);

        // ---- resync on repeated a-tag
        err_cnt = 0;
        send(2'b00, 8'd5);
        send(2'b00, 8'd6);
        check("resync_err_pulse", 32'(err), 32'd1);
        send(2'b01, 8'd7);
        check("resync_err_clear", 32'(err), 32'd0);
        send(2'b10, 8'd8);
        check_out("resync", 8'd6, 8'd7, 8'd8);
        idle(1);
        check("resync_err_count", 32'(err_cnt), 32'd1);

        // ---- illegal tag
        err_cnt = 0;
        send(2'b00, 8'd1);
        send(2'b11, 8'd2);
        check("illegal_err_pulse", 32'(err), 32'd1);
        send(2'b00, 8'd3);
        send(2'b01, 8'd4);
        send(2'b10, 8'd5);
        check_out("illegal", 8'd3, 8'd4, 8'd5);
        idle(1);
        check("illegal_err_count", 32'(err_cnt), 32'd1);

        // ---- flush drops a partial triplet and blocks the beat in its cycle
        err_cnt = 0;
        send(2'b00, 8'h09);
        send(2'b01, 8'h0A);
        flush    = 1'b1;
        in_sel   = 2'b10;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_no_output", 32'(out_valid), 32'd0);
        send(2'b00, 8'h09);
        send(2'b01, 8'h0A);
        check("flush_no_early_output", 32'(out_valid), 32'd0);
        send(2'b10, 8'h0B);
        check_out("flush", 8'h09, 8'h0A, 8'h0B);
        idle(1);
        check("flush_err_count", 32'(err_cnt), 32'd0);

        // ---- asynchronous reset while a triplet is pending
        out_ready = 1'b0;
        send(2'b00, 8'h21);
        send(2'b01, 8'h42);
        send(2'b10, 8'h63);
        check_out("prereset", 8'h21, 8'h42, 8'h63);
        rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_a", 32'(out_a), 32'd0);
        check("areset_b", 32'(out_b), 32'd0);
        check("areset_c", 32'(out_c), 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // ---- 9-bit instance, no truncation
        in_sel9 = 2'b00; in_data9 = 9'h1FF; in_valid9 = 1'b1;
        @(posedge clk); #1;
        in_sel9 = 2'b01; in_data9 = 9'h100;
        @(posedge clk); #1;
        in_sel9 = 2'b10; in_data9 = 9'h0FF;
        @(posedge clk); #1;
        in_valid9 = 1'b0;
        check("w9_valid", 32'(out_valid9), 32'd1);
        check("w9_a", 32'(out_a9), 32'h1FF);
        check("w9_b", 32'(out_b9), 32'h100);
        check("w9_c", 32'(out_c9), 32'h0FF);
        idle(1);
        check("w9_err_count", 32'(err9_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_channel_demux_3
